// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream in, big-endian words out.
// Holds the CPU in reset until a checksummed image is in memory.
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [8:0] DEPTH_B = 9'(DEPTH);

  state_t state;
  state_t state_nxt;

  logic [1:0]       byte_cnt;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] n_words;
  logic [7:0]       csum;
  logic [23:0]      word;

  logic xfer;
  logic hdr_bad;
  logic word_end;
  logic last_word;
  logic ready_nxt;

  assign xfer      = rx_valid & rx_ready;
  assign hdr_bad   = (rx_data == 8'd0) ||
                     ({1'b0, rx_data} > DEPTH_B);
  assign word_end  = (byte_cnt == 2'd3);
  assign last_word = (word_idx == n_words - CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_reset = 1'b1;
    ready_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        busy = 1'b1;
        if (xfer) begin
          state_nxt = hdr_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (xfer && word_end && last_word) begin
          state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        busy = 1'b1;
        if (xfer) begin
          state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) state_nxt = S_HDR;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nxt = S_HDR;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // ready only once a receiving state has been entered
    ready_nxt = (state_nxt == state) &&
                (busy == 1'b1);
  end

  // Handshake, word assembly, checksum and write strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= 32'd0;
      wr_data  <= 32'd0;
      byte_cnt <= 2'd0;
      word_idx <= '0;
      n_words  <= '0;
      csum     <= 8'd0;
      word     <= 24'd0;
    end else begin
      rx_ready <= ready_nxt;
      wr_en    <= 1'b0;
      if (state == S_HDR && xfer && !hdr_bad) begin
        n_words  <= rx_data[CNT_W-1:0];
        byte_cnt <= 2'd0;
        word_idx <= '0;
        csum     <= 8'd0;
        word     <= 24'd0;
      end
      if (state == S_DATA && xfer) begin
        word     <= {word[15:0], rx_data};
        csum     <= csum + rx_data;
        byte_cnt <= byte_cnt + 2'd1;
        if (word_end) begin
          wr_en    <= 1'b1;
          wr_addr  <= {{(30-CNT_W){1'b0}},
                       word_idx, 2'b00};
          wr_data  <= {word, rx_data};
          word_idx <= word_idx + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random images
// checked against a stream-level reference model.
module tb_imem_loader;

  typedef logic [7:0] u8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [63:0] wq[$];
  logic [63:0] exp_w[$];
  bit          exp_ok;
  int          exp_len;

  imem_loader #(.DEPTH(32), .CNT_W(6)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // capture every write strobe as {addr, data}
  always @(negedge clk) begin
    if (reset_n && wr_en) wq.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // reference: parse image, list expected writes and outcome
  function automatic void model(input u8 s[$]);
    int n;
    int sum;
    logic [31:0] w;
    n = int'(s[0]);
    sum = 0;
    exp_w.delete();
    if (n == 0 || n > 32) begin
      exp_ok = 1'b0;
      exp_len = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {s[1+4*i], s[2+4*i], s[3+4*i], s[4+4*i]};
      exp_w.push_back({32'(i * 4), w});
      for (int k = 1; k <= 4; k++) sum += int'(s[k+4*i]);
    end
    exp_len = 4 * n + 2;
    exp_ok = (int'(s[4*n+1]) == (sum % 256));
  endfunction

  task automatic drive(input u8 s[$], input int len,
                       input int mode, input int start_at);
    int idx;
    int cyc;
    bit ok;
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 3000) begin
      @(negedge clk);
      case (mode)
        0: rx_valid = 1'b1;
        1: rx_valid = (cyc % 3 == 0);
        default: rx_valid = 1'($urandom_range(0, 1));
      endcase
      rx_data = s[idx];
      start = (cyc == start_at);
      ok = rx_valid && rx_ready;
      @(posedge clk);
      if (ok) idx++;
      cyc++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start = 1'b0;
    chk("bytes_accepted", 64'(idx), 64'(len));
  endtask

  task automatic run_load(input u8 s[$], input int mode,
                          input bit do_start,
                          input int start_at,
                          input string tag);
    int c;
    int nw;
    model(s);
    wq.delete();
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    drive(s, exp_len, mode, start_at);
    c = 0;
    while (!(done || err) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, 64'(done), 64'(exp_ok));
    chk({tag, "_err"}, 64'(err), 64'(!exp_ok));
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(!exp_ok));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({tag, "_nwrites"}, 64'(wq.size()),
        64'(exp_w.size()));
    nw = (wq.size() < exp_w.size()) ? wq.size()
                                     : exp_w.size();
    for (int i = 0; i < nw; i++) begin
      chk({tag, "_write"}, wq[i], exp_w[i]);
    end
  endtask

  u8 norm[$];
  u8 badc[$];
  u8 h0[$];
  u8 h33[$];
  u8 rs[$];

  initial begin
    int n;
    int pick;
    u8 cs;
    norm = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h00,
             8'h20, 8'h09, 8'h00, 8'h28, 8'h79};
    badc = norm;
    badc[9] = 8'h7A;
    h0 = '{8'h00};
    h33 = '{8'h21};

    reset_n = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset_n = 1'b1;

    run_load(norm, 0, 1'b1, -1, "normal");
    chk("normal_w0", (wq.size() > 0) ? wq[0] : 64'd0,
        {32'd0, 32'h20080000});
    chk("normal_w1", (wq.size() > 1) ? wq[1] : 64'd0,
        {32'd4, 32'h20090028});

    run_load(badc, 0, 1'b1, -1, "badcsum");
    run_load(h0, 0, 1'b1, -1, "hdr00");
    run_load(h33, 0, 1'b1, -1, "hdr21");
    run_load(norm, 1, 1'b1, -1, "toggle");

    // reset after six bytes: one write done, then abort
    model(norm);
    wq.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(norm, 6, 0, -1);
    reset_n = 1'b0;
    #1;
    chk("mid_rx_ready", 64'(rx_ready), 64'd0);
    chk("mid_wr_en", 64'(wr_en), 64'd0);
    chk("mid_wr_addr", 64'(wr_addr), 64'd0);
    chk("mid_wr_data", 64'(wr_data), 64'd0);
    chk("mid_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_nwrites", 64'(wq.size()), 64'd1);
    chk("mid_w0", (wq.size() > 0) ? wq[0] : 64'd0,
        {32'd0, 32'h20080000});
    @(negedge clk);
    reset_n = 1'b1;
    run_load(norm, 0, 1'b1, -1, "after_rst");

    // start pulse while in DATA is ignored
    run_load(norm, 0, 1'b1, 6, "start_in_data");

    // start in DONE restarts into HDR
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_rx_ready", 64'(rx_ready), 64'd0);
    run_load(norm, 2, 1'b0, -1, "restart_load");

    for (int it = 0; it < 8; it++) begin
      rs.delete();
      pick = $urandom_range(0, 9);
      if (pick == 0) n = 0;
      else if (pick == 1) n = $urandom_range(33, 255);
      else n = $urandom_range(1, 6);
      rs.push_back(u8'(n));
      if (n >= 1 && n <= 32) begin
        cs = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
          rs.push_back(u8'($urandom_range(0, 255)));
          cs = cs + rs[i+1];
        end
        if ($urandom_range(0, 3) == 0) cs = cs + 8'd1;
        rs.push_back(cs);
      end
      run_load(rs, $urandom_range(0, 2), 1'b1, -1,
               "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory, which the CPU only reads.
- Receives a program image as a byte stream over a valid/ready handshake.
- Assembles the bytes into 32-bit big-endian words and writes them sequentially into instruction memory starting at byte address 0.
- Holds the CPU in reset until a complete image has loaded and passed its checksum.

Parameters:
- DEPTH, 32, number of instruction memory words; the maximum accepted word count.
- CNT_W, 6, width of the word counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load.
- rx_valid  input  1  rx_data holds a valid byte.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction-memory write strobe.
- wr_addr  output  32  byte address of the write; always word aligned.
- wr_data  output  32  assembled word.
- cpu_reset  output  1  active-high reset driven to the CPU's reset input.
- busy  output  1  load in progress.
- done  output  1  last load succeeded; sticky.
- err  output  1  last load failed; sticky.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: state IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=1, busy=0, done=0, err=0. Internal byte counter, word counter and checksum are all 0.
- Stream format:
  - Byte 0 is N, the word count.
  - Then 4*N data bytes, MSB first within each word.
  - Then one checksum byte equal to the sum of all 4*N data bytes modulo 256. The header byte is not summed.
- Handshake: a byte transfers on any cycle with rx_valid=1 and rx_ready=1. rx_ready is registered and is 1 only in states HDR, DATA and CSUM. rx_valid may drop for any number of cycles without side effects.
- IDLE:
  - start=1 moves to HDR next cycle.
  - cpu_reset stays 1.
- HDR:
  - On transfer, if N==0 or N>DEPTH, go to ERR.
  - Otherwise latch N, clear counters and checksum, and go to DATA.
  - busy=1 in HDR, DATA and CSUM.
- DATA:
  - Each transfer shifts the byte into the word register (word = {word[23:0], byte}) and adds it to the checksum (8-bit, wraps).
  - On the 4th byte of a word, wr_en=1 for exactly the next cycle, with wr_addr = word_index*4 and wr_data = the assembled word. Then word_index increments.
  - Back-to-back bytes are accepted with no bubble; a write strobe may overlap acceptance of the next word's first byte.
  - After word N-1 is assembled, go to CSUM.
- CSUM:
  - On transfer, if the byte equals the checksum, go to DONE; otherwise go to ERR.
- DONE: done=1, cpu_reset=0, rx_ready=0.
- ERR: err=1, cpu_reset=1, rx_ready=0. Words already written are not rolled back.
- start in DONE or ERR clears done and err, sets cpu_reset=1, and moves to HDR next cycle.
- start in HDR, DATA or CSUM is ignored.
- wr_addr wraps never: N<=DEPTH bounds it to (DEPTH-1)*4.
- Reset mid-load: all outputs return to reset values immediately and the partial word is discarded. Memory contents already written remain. The next start begins a fresh load.
- A byte presented in the same cycle a state is entered is not accepted, because rx_ready is registered.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 02,20,08,00,00,20,09,00,28,79 with rx_valid held high.
  - Required response: wr_en pulses twice, addr 0 data 0x20080000 and addr 4 data 0x20090028. Then done=1, err=0, cpu_reset=0, busy=0.
- Same stream, checksum byte 7A -> both writes occur, then err=1, done=0, cpu_reset=1.
- Header 00, and separately header 21 (33 > DEPTH) -> err=1 after the header byte, no wr_en, rx_ready=0.
- Normal load with rx_valid toggling 1,0,0,1,... -> identical write sequence and final outputs as the normal load; no byte accepted while rx_valid=0.
- Reset mid-load:
  - Stimulus: assert reset_n=0 after 6 bytes of the normal load.
  - Required response: outputs return to reset values at once, with exactly one write (addr 0) having occurred.
  - A subsequent full normal load then completes with done=1.
- Start handling:
  - start pulsed during DATA -> no effect; the load completes normally.
  - start pulsed in DONE -> done=0 and cpu_reset=1 the next cycle, state HDR.
